axi_lite_arbiter: RTL and testbench
===================================

Name: axi_lite_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter.
- Shares a single `axi` slave port, such as a peripheral register block, between two `axi` masters, such as a CPU instruction port and a data port.
- Read and write paths are arbitrated independently, each with round-robin priority.
- Each path allows one outstanding transaction; the path is locked to the granted master until its response handshake completes.

Parameters:
- ADDR_WIDTH, 32, address width of all three `axi` interfaces; must match the instantiated interfaces.
- DATA_WIDTH, 32, data width of all three interfaces; strobe width is DATA_WIDTH/8.

Ports:
- aclk  input  1  clock; all state updates on the rising edge.
- areset  input  1  reset, synchronous and active-high.
- s0  axi.slave  interface  requester 0; higher priority out of reset.
- s1  axi.slave  interface  requester 1.
- m  axi.master  interface  downstream shared slave.

Behaviour:
Reset:
- While areset=1 at a clock edge:
  - both path FSMs go to IDLE;
  - both round-robin pointers select s0 next;
  - aw_done and w_done clear.
- Combinational consequence: every valid/ready output on s0, s1 and m is 0.
- Data, addr, prot, strb and resp outputs are don't-care when the matching valid is 0. They are driven 0 when the channel is not granted.
- Reset mid-transaction abandons it; no completion is issued to either master.

Write path FSM, states W_IDLE, W_ADDR, W_RESP:
- W_IDLE:
  - Requests are s0.awvalid and s1.awvalid; wvalid alone is not a request.
  - One request: grant it. Both requesting: grant the master indicated by the pointer.
  - Register grant index wg and go to W_ADDR. No channel is forwarded in W_IDLE, so there is 1 cycle of arbitration latency.
- W_ADDR:
  - m.aw* = s[wg].aw*, with m.awvalid = s[wg].awvalid & ~aw_done; s[wg].awready = m.awready & ~aw_done.
  - W channel forwarded the same way under w_done.
  - aw_done/w_done set on their respective handshakes. AW and W may complete in either order or in the same cycle.
  - When both are done (registered or completing this cycle), go to W_RESP and clear aw_done and w_done.
- W_RESP:
  - m.bready = s[wg].bready; s[wg].bvalid = m.bvalid; s[wg].bresp = m.bresp.
  - On m.bvalid & m.bready: pointer := ~wg, then go to W_IDLE.
- Non-granted master: awready = wready = bvalid = 0 in all states.

Read path FSM, states R_IDLE, R_ADDR, R_DATA:
- Same structure as the write path.
- Request is arvalid; grant index rg.
- R_ADDR forwards the AR channel and moves to R_DATA on the AR handshake.
- R_DATA forwards rdata/rresp/rvalid/rready and returns to R_IDLE on the R handshake, with pointer := ~rg.
- The read pointer is independent of the write pointer.

Concurrency and boundaries:
- Read and write paths may be busy at the same time, on the same or different masters.
- Request inputs are sampled only in IDLE. A master dropping awvalid/arvalid after grant is an AXI protocol violation; behaviour is unspecified.
- Response channels pass through with 0 added latency.
- A new grant occurs no earlier than the cycle after the response handshake. Steady-state back-to-back throughput is one transaction per (3 + slave latency) cycles per path.
- A single persistent requester is re-granted every time; the pointer only breaks ties.

Test Plan:
- Single write: s0 writes addr 0x10, data 0xDEADBEEF, strb 0xF; slave has 0-wait ready and bresp OKAY. Required: m.awvalid rises 1 cycle after s0.awvalid; s0 sees bvalid with bresp 0; s1 sees no ready/valid.
- Tie round-robin: s0 and s1 both issue writes in the cycle after reset, then both reissue immediately. Required: grant order s0, s1, s0, s1. Slave sees addresses in that order, data matched to address.
- Independent paths: s1 reads 0x20 while s0 writes 0x30, started the same cycle; slave holds arready 3 cycles. Required: the write completes without waiting for the read; s1.rdata equals slave data 0x12345678.
- W before AW with backpressure: s0 asserts wvalid 2 cycles before awvalid; m.bvalid is held while s0.bready=0 for 4 cycles. Required: wready stays 0 until grant; FSM remains in W_RESP; exactly one B handshake.
- Reset mid-transaction: assert areset for 1 cycle while in W_ADDR with aw_done=1. Required: next cycle all valid/ready outputs are 0, pointer selects s0, and a fresh s1 write then completes normally.
- Error propagation: slave returns rresp SLVERR (2'b10) for an s1 read. Required: s1.rresp = 2'b10 and the next read tie is granted to s0.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Two-requester to one-completer AXI4-Lite arbiter.
// Read and write paths are arbitrated independently with round-robin priority.
// Each path holds one outstanding transaction and stays locked to its grant
// until the response handshake completes.
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  // requester 0
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
  input  logic [2:0]                s0_awprot,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr,
  input  logic [2:0]                s0_arprot,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
  input  logic [2:0]                s1_awprot,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr,
  input  logic [2:0]                s1_arprot,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,
  // shared downstream completer
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic     wg, wg_nxt, w_ptr, w_ptr_nxt;
  logic     rg, rg_nxt, r_ptr, r_ptr_nxt;
  logic     aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic     aw_hs, w_hs;

  // Write path registers: state, grant index, tie-break pointer, AW/W completion flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      wg      <= 1'b0;
      w_ptr   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      wg      <= wg_nxt;
      w_ptr   <= w_ptr_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Write path next-state and AW/W/B channel steering
  always_comb begin
    w_state_nxt = w_state;
    wg_nxt      = wg;
    w_ptr_nxt   = w_ptr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    m_awaddr    = '0;
    m_awprot    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    s0_awready  = 1'b0;
    s0_wready   = 1'b0;
    s0_bvalid   = 1'b0;
    s0_bresp    = '0;
    s1_awready  = 1'b0;
    s1_wready   = 1'b0;
    s1_bvalid   = 1'b0;
    s1_bresp    = '0;
    case (w_state)
      W_IDLE: begin
        if (s0_awvalid || s1_awvalid) begin
          wg_nxt      = (s0_awvalid && s1_awvalid) ? w_ptr : s1_awvalid;
          w_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awaddr   = wg ? s1_awaddr : s0_awaddr;
        m_awprot   = wg ? s1_awprot : s0_awprot;
        m_awvalid  = (wg ? s1_awvalid : s0_awvalid) & ~aw_done;
        m_wdata    = wg ? s1_wdata : s0_wdata;
        m_wstrb    = wg ? s1_wstrb : s0_wstrb;
        m_wvalid   = (wg ? s1_wvalid : s0_wvalid) & ~w_done;
        s0_awready = ~wg & m_awready & ~aw_done;
        s1_awready =  wg & m_awready & ~aw_done;
        s0_wready  = ~wg & m_wready & ~w_done;
        s1_wready  =  wg & m_wready & ~w_done;
        aw_hs      = m_awvalid & m_awready;
        w_hs       = m_wvalid & m_wready;
        // AW and W may finish in either order or together; leave once both are in
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          w_state_nxt = W_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end
      W_RESP: begin
        m_bready  = wg ? s1_bready : s0_bready;
        s0_bvalid = ~wg & m_bvalid;
        s1_bvalid =  wg & m_bvalid;
        s0_bresp  = wg ? '0 : m_bresp;
        s1_bresp  = wg ? m_bresp : '0;
        if (m_bvalid && m_bready) begin
          w_ptr_nxt   = ~wg;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read path registers: state, grant index, tie-break pointer
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      rg      <= 1'b0;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      rg      <= rg_nxt;
      r_ptr   <= r_ptr_nxt;
    end
  end

  // Read path next-state and AR/R channel steering
  always_comb begin
    r_state_nxt = r_state;
    rg_nxt      = rg;
    r_ptr_nxt   = r_ptr;
    m_araddr    = '0;
    m_arprot    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    s0_arready  = 1'b0;
    s0_rdata    = '0;
    s0_rresp    = '0;
    s0_rvalid   = 1'b0;
    s1_arready  = 1'b0;
    s1_rdata    = '0;
    s1_rresp    = '0;
    s1_rvalid   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          rg_nxt      = (s0_arvalid && s1_arvalid) ? r_ptr : s1_arvalid;
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        m_araddr   = rg ? s1_araddr : s0_araddr;
        m_arprot   = rg ? s1_arprot : s0_arprot;
        m_arvalid  = rg ? s1_arvalid : s0_arvalid;
        s0_arready = ~rg & m_arready;
        s1_arready =  rg & m_arready;
        if (m_arvalid && m_arready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        m_rready  = rg ? s1_rready : s0_rready;
        s0_rvalid = ~rg & m_rvalid;
        s1_rvalid =  rg & m_rvalid;
        s0_rdata  = rg ? '0 : m_rdata;
        s1_rdata  = rg ? m_rdata : '0;
        s0_rresp  = rg ? '0 : m_rresp;
        s1_rresp  = rg ? m_rresp : '0;
        if (m_rvalid && m_rready) begin
          r_ptr_nxt   = ~rg;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: directed requester traffic, a simple
// completer model on the shared port, and a monitor that checks every handshake.
module tb_axi_lite_arbiter;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  // requester-side drive (index = requester number)
  logic [1:0]  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr [2];
  logic [31:0] s_wdata  [2];
  logic [31:0] s_araddr [2];
  logic [3:0]  s_wstrb  [2];
  logic [2:0]  s_awprot [2];
  logic [2:0]  s_arprot [2];

  // requester-side DUT outputs
  logic        s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
  logic        s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
  logic [1:0]  s0_bresp, s1_bresp, s0_rresp, s1_rresp;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp [2];
  logic [1:0]  s_rresp [2];
  logic [31:0] s_rdata [2];
  assign s_awready = {s1_awready, s0_awready};
  assign s_wready  = {s1_wready,  s0_wready};
  assign s_bvalid  = {s1_bvalid,  s0_bvalid};
  assign s_arready = {s1_arready, s0_arready};
  assign s_rvalid  = {s1_rvalid,  s0_rvalid};
  assign s_bresp[0] = s0_bresp;
  assign s_bresp[1] = s1_bresp;
  assign s_rresp[0] = s0_rresp;
  assign s_rresp[1] = s1_rresp;
  assign s_rdata[0] = s0_rdata;
  assign s_rdata[1] = s1_rdata;

  // shared port
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .s0_awaddr(s_awaddr[0]), .s0_awprot(s_awprot[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s0_awready),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s_bready[0]),
    .s0_araddr(s_araddr[0]), .s0_arprot(s_arprot[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s_rready[0]),
    .s1_awaddr(s_awaddr[1]), .s1_awprot(s_awprot[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s1_awready),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s_bready[1]),
    .s1_araddr(s_araddr[1]), .s1_arprot(s_arprot[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s_rready[1]),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // ---------------- completer model ----------------
  int          slv_ar_wait;
  logic [31:0] slv_rdata;
  logic [1:0]  slv_rresp, slv_bresp;
  logic        aw_seen, w_seen;
  int          ar_cnt;

  assign m_awready = 1'b1;
  assign m_wready  = 1'b1;
  assign m_arready = m_arvalid && (ar_cnt >= slv_ar_wait);

  // Completer: B one cycle after both AW and W seen; R one cycle after AR
  always @(posedge aclk) begin
    if (areset) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; m_bvalid <= 1'b0; m_bresp <= '0;
      ar_cnt <= 0; m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
    end else begin
      if (m_awvalid && m_awready) aw_seen <= 1'b1;
      if (m_wvalid && m_wready) w_seen <= 1'b1;
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      else if (aw_seen && w_seen && !m_bvalid) begin
        m_bvalid <= 1'b1; m_bresp <= slv_bresp; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        ar_cnt <= 0; m_rvalid <= 1'b1; m_rdata <= slv_rdata; m_rresp <= slv_rresp;
      end else if (m_arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int b_cnt [2];
  logic [34:0] exp_aw [$];
  logic [35:0] exp_w  [$];
  logic [34:0] exp_ar [$];
  logic [1:0]  exp_b0 [$];
  logic [1:0]  exp_b1 [$];
  logic [33:0] exp_r0 [$];
  logic [33:0] exp_r1 [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] prot_of(input int i);
    return (i == 0) ? 3'b001 : 3'b010;
  endfunction

  function automatic logic [14:0] vr_outs();
    return {s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid,
            s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid,
            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
  endfunction

  task automatic push_wr(input int i, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] bresp);
    exp_aw.push_back({prot_of(i), addr});
    exp_w.push_back({strb, data});
    if (i == 0) exp_b0.push_back(bresp); else exp_b1.push_back(bresp);
  endtask

  task automatic push_rd(input int i, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] rresp);
    exp_ar.push_back({prot_of(i), addr});
    if (i == 0) exp_r0.push_back({rresp, data}); else exp_r1.push_back({rresp, data});
  endtask

  task automatic mon_b(input int i);
    logic [1:0] e;
    bit have;
    have = 0;
    e = '0;
    if (i == 0 && exp_b0.size() > 0) begin e = exp_b0.pop_front(); have = 1; end
    if (i == 1 && exp_b1.size() > 0) begin e = exp_b1.pop_front(); have = 1; end
    if (!have) chk((i == 0) ? "s0_b_unexpected" : "s1_b_unexpected", 1, 0);
    else       chk((i == 0) ? "s0_bresp" : "s1_bresp", s_bresp[i], e);
  endtask

  task automatic mon_r(input int i);
    logic [33:0] e;
    bit have;
    have = 0;
    e = '0;
    if (i == 0 && exp_r0.size() > 0) begin e = exp_r0.pop_front(); have = 1; end
    if (i == 1 && exp_r1.size() > 0) begin e = exp_r1.pop_front(); have = 1; end
    if (!have) chk((i == 0) ? "s0_r_unexpected" : "s1_r_unexpected", 1, 0);
    else       chk((i == 0) ? "s0_rresp_rdata" : "s1_rresp_rdata", {s_rresp[i], s_rdata[i]}, e);
  endtask

  task automatic monitor();
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (m_awvalid && m_awready) begin
          if (exp_aw.size() == 0) chk("m_aw_unexpected", 1, 0);
          else chk("m_aw_prot_addr", {m_awprot, m_awaddr}, exp_aw.pop_front());
        end
        if (m_wvalid && m_wready) begin
          if (exp_w.size() == 0) chk("m_w_unexpected", 1, 0);
          else chk("m_w_strb_data", {m_wstrb, m_wdata}, exp_w.pop_front());
        end
        if (m_arvalid && m_arready) begin
          if (exp_ar.size() == 0) chk("m_ar_unexpected", 1, 0);
          else chk("m_ar_prot_addr", {m_arprot, m_araddr}, exp_ar.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
          if (s_bvalid[i] && s_bready[i]) begin b_cnt[i]++; mon_b(i); end
          if (s_rvalid[i] && s_rready[i]) mon_r(i);
        end
      end
    end
  endtask

  // ---------------- requester drivers ----------------
  task automatic sync();
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) sync();
    areset = 1'b0;
  endtask

  task automatic mst_write(input int i, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_delay);
    bit aw_ok, w_ok, ah, wh, hs;
    int t;
    s_wdata[i] = data; s_wstrb[i] = strb; s_wvalid[i] = 1'b1;
    s_bready[i] = (b_delay == 0);
    for (int k = 0; k < w_lead; k++) begin
      @(negedge aclk); chk("w_lead_wready", s_wready[i], 0);
      sync();
    end
    s_awaddr[i] = addr; s_awvalid[i] = 1'b1;
    aw_ok = 0; w_ok = 0; t = 0;
    while (!(aw_ok && w_ok) && t < 50) begin
      @(negedge aclk);
      ah = s_awvalid[i] & s_awready[i];
      wh = s_wvalid[i] & s_wready[i];
      sync();
      if (ah) begin s_awvalid[i] = 1'b0; aw_ok = 1; end
      if (wh) begin s_wvalid[i] = 1'b0; w_ok = 1; end
      t++;
    end
    if (!(aw_ok && w_ok)) begin
      chk("aw_w_timeout", 0, 1);
      s_awvalid[i] = 1'b0; s_wvalid[i] = 1'b0; s_bready[i] = 1'b0;
      return;
    end
    if (b_delay > 0) begin
      hs = 0; t = 0;
      while (!hs && t < 50) begin
        @(negedge aclk); hs = s_bvalid[i];
        if (!hs) sync();
        t++;
      end
      if (!hs) begin chk("bvalid_timeout", 0, 1); return; end
      for (int k = 1; k < b_delay; k++) begin
        sync(); @(negedge aclk);
        chk("b_held_bvalid", s_bvalid[i], 1);
        chk("b_held_m_bready", m_bready, 0);
      end
      sync();
      s_bready[i] = 1'b1;
    end
    hs = 0; t = 0;
    while (!hs && t < 50) begin
      @(negedge aclk); hs = s_bvalid[i] & s_bready[i];
      sync();
      t++;
    end
    s_bready[i] = 1'b0;
    if (!hs) chk("b_timeout", 0, 1);
  endtask

  task automatic mst_read(input int i, input logic [31:0] addr);
    bit hs;
    int t;
    s_araddr[i] = addr; s_arvalid[i] = 1'b1; s_rready[i] = 1'b1;
    hs = 0; t = 0;
    while (!hs && t < 50) begin
      @(negedge aclk); hs = s_arvalid[i] & s_arready[i];
      sync();
      t++;
    end
    s_arvalid[i] = 1'b0;
    if (!hs) begin chk("ar_timeout", 0, 1); s_rready[i] = 1'b0; return; end
    hs = 0; t = 0;
    while (!hs && t < 50) begin
      @(negedge aclk); hs = s_rvalid[i] & s_rready[i];
      sync();
      t++;
    end
    s_rready[i] = 1'b0;
    if (!hs) chk("r_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] quiet;
    time t_w, t_r;
    int b_before;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    for (int i = 0; i < 2; i++) begin
      s_awaddr[i] = '0; s_wdata[i] = '0; s_araddr[i] = '0; s_wstrb[i] = '0;
      s_awprot[i] = prot_of(i); s_arprot[i] = prot_of(i); b_cnt[i] = 0;
    end
    slv_ar_wait = 0; slv_rdata = '0; slv_rresp = 2'b00; slv_bresp = 2'b00;
    areset = 1'b1;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
      end
    join_none

    // reset state
    sync();
    @(negedge aclk); chk("reset_valid_ready", vr_outs(), 0);
    sync();
    areset = 1'b0;

    // single write from s0, one-cycle arbitration latency, s1 stays quiet
    sync();
    push_wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    quiet = '0;
    fork
      mst_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      begin
        @(negedge aclk); chk("t1_m_awvalid_arb_cycle", m_awvalid, 0);
        @(negedge aclk); chk("t1_m_awvalid_granted", m_awvalid, 1);
      end
      repeat (8) begin
        @(negedge aclk);
        quiet = quiet | {s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid};
      end
    join
    chk("t1_s1_quiet", quiet, 0);

    // tie after reset: s0, s1, s0, s1
    do_reset();
    push_wr(0, 32'h100, 32'hA0A0A0A0, 4'hF, 2'b00);
    push_wr(1, 32'h104, 32'hB1B1B1B1, 4'h3, 2'b00);
    push_wr(0, 32'h108, 32'hA2A2A2A2, 4'hC, 2'b00);
    push_wr(1, 32'h10C, 32'hB3B3B3B3, 4'h1, 2'b00);
    fork
      begin
        mst_write(0, 32'h100, 32'hA0A0A0A0, 4'hF, 0, 0);
        mst_write(0, 32'h108, 32'hA2A2A2A2, 4'hC, 0, 0);
      end
      begin
        mst_write(1, 32'h104, 32'hB1B1B1B1, 4'h3, 0, 0);
        mst_write(1, 32'h10C, 32'hB3B3B3B3, 4'h1, 0, 0);
      end
    join

    // independent paths: s1 read stalled by completer while s0 writes
    sync();
    slv_ar_wait = 3; slv_rdata = 32'h12345678; slv_rresp = 2'b00;
    push_rd(1, 32'h20, 32'h12345678, 2'b00);
    push_wr(0, 32'h30, 32'h0000C0DE, 4'hF, 2'b00);
    fork
      begin mst_write(0, 32'h30, 32'h0000C0DE, 4'hF, 0, 0); t_w = $time; end
      begin mst_read(1, 32'h20); t_r = $time; end
    join
    chk("t3_write_not_blocked_by_read", (t_w < t_r), 1);
    slv_ar_wait = 0;

    // W ahead of AW, then B backpressure for 4 cycles
    sync();
    b_before = b_cnt[0];
    push_wr(0, 32'h40, 32'h55AA55AA, 4'h5, 2'b00);
    mst_write(0, 32'h40, 32'h55AA55AA, 4'h5, 2, 4);
    repeat (4) sync();
    chk("t4_single_b_handshake", b_cnt[0] - b_before, 1);

    // reset in W_ADDR with aw_done set
    sync();
    push_wr(0, 32'h50, 32'h0, 4'h0, 2'b00);
    void'(exp_w.pop_back());
    void'(exp_b0.pop_back());
    s_awaddr[0] = 32'h50; s_awvalid[0] = 1'b1;
    repeat (2) sync();
    @(negedge aclk);
    chk("t5_awvalid_masked_after_aw", {m_awvalid, s0_awready}, 0);
    sync();
    s_awvalid[0] = 1'b0;
    areset = 1'b1;
    sync();
    areset = 1'b0;
    @(negedge aclk); chk("t5_post_reset_valid_ready", vr_outs(), 0);
    sync();
    push_wr(0, 32'h60, 32'h60606060, 4'hF, 2'b00);
    push_wr(1, 32'h64, 32'h64646464, 4'hF, 2'b00);
    fork
      mst_write(0, 32'h60, 32'h60606060, 4'hF, 0, 0);
      mst_write(1, 32'h64, 32'h64646464, 4'hF, 0, 0);
    join

    // read error propagation and read pointer update
    sync();
    slv_rdata = 32'h0000AAAA; slv_rresp = 2'b00;
    push_rd(0, 32'h68, 32'h0000AAAA, 2'b00);
    mst_read(0, 32'h68);
    slv_rdata = 32'hBAD0BAD0; slv_rresp = 2'b10;
    push_rd(1, 32'h70, 32'hBAD0BAD0, 2'b10);
    mst_read(1, 32'h70);
    slv_rdata = 32'h5A5A0000; slv_rresp = 2'b00;
    push_rd(0, 32'h80, 32'h5A5A0000, 2'b00);
    push_rd(1, 32'h84, 32'h5A5A0000, 2'b00);
    fork
      mst_read(0, 32'h80);
      mst_read(1, 32'h84);
    join

    // every expected transfer was observed
    repeat (5) sync();
    chk("end_aw_pending", exp_aw.size(), 0);
    chk("end_w_pending", exp_w.size(), 0);
    chk("end_ar_pending", exp_ar.size(), 0);
    chk("end_b_pending", exp_b0.size() + exp_b1.size(), 0);
    chk("end_r_pending", exp_r0.size() + exp_r1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
